// File: rtl/cdc_hs_pkg.sv
// Shared types and helpers for the 4-phase req/ack crossing source side.
// Holds the FSM state encoding, synchronizer depth and the round-robin picker.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  localparam int SYNC_STAGES = 3;
  localparam int MAX_NREQ    = 8;
  localparam int MAX_IDW     = 3;

  // One-hot of the first valid requester at or above ptr, wrapping at nreq.
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] valid,
    input logic [MAX_IDW-1:0]  ptr,
    input int                  nreq
  );
    logic [MAX_NREQ-1:0] grant;
    logic                found;
    int                  idx;
    grant = {MAX_NREQ{1'b0}};
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= nreq) begin
        idx = idx - nreq;
      end
      if (!found && (k < nreq) && valid[idx[MAX_IDW-1:0]]) begin
        grant[idx[MAX_IDW-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/synchronizer_4.sv
// Multi-flop synchronizer for slow or level signals entering the clk domain.
// Depth is parameterised; the output is the last flop of the chain.
module synchronizer_4 #(
  parameter int DW     = 1,
  parameter int STAGES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_sync [STAGES];

  // Shift chain, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_sync[k] <= {DW{1'b0}};
      end
    end else begin
      r_sync[0] <= i_d;
      for (int k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack crossing shared round-robin by NREQ requesters.
// xdata/xid are held stable for the whole transfer; a per-phase timeout breaks a dead far side.
module cdc_handshake_tx
  import cdc_hs_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NREQ  = 2,
  parameter int TMO_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DW-1:0]    req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  xreq,
  output logic [DW-1:0]         xdata,
  output logic [$clog2(NREQ)-1:0] xid,
  input  logic                  xack,
  output logic                  busy,
  output logic                  xfer_done,
  input  logic [TMO_W-1:0]      tmo_limit,
  output logic                  tmo_err,
  input  logic                  err_clr
);

  localparam int IDW = $clog2(NREQ);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [TMO_W-1:0]    r_cnt;
  logic [TMO_W-1:0]    w_cnt_nxt;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      w_ptr_nxt;
  logic                r_xreq;
  logic                w_xreq_nxt;
  logic [DW-1:0]       r_xdata;
  logic [IDW-1:0]      r_xid;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_tmo_err;
  logic                w_tmo_err_nxt;
  logic                r_abort;
  logic                w_abort_nxt;
  logic                w_ack_s;
  logic                w_tmo_hit;
  logic                w_tmo_fire;
  logic                w_accept;
  logic [MAX_NREQ-1:0] w_pick;
  logic [NREQ-1:0]     w_grant;
  logic [IDW-1:0]      w_gidx;

  synchronizer_4 #(
    .DW     (1),
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (xack),
    .o_q   (w_ack_s)
  );

  // Round-robin grant, offered only while idle.
  always_comb begin
    w_pick = rr_pick(MAX_NREQ'(req_valid), MAX_IDW'(r_ptr), NREQ);
    if (r_state == IDLE) begin
      w_grant = w_pick[NREQ-1:0];
    end else begin
      w_grant = {NREQ{1'b0}};
    end
    w_gidx = {IDW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      w_gidx = w_gidx | (w_grant[k] ? IDW'(k) : {IDW{1'b0}});
    end
  end

  assign w_accept  = |w_grant;
  assign w_tmo_hit = (tmo_limit != {TMO_W{1'b0}}) && (r_cnt == (tmo_limit - TMO_W'(1)));
  assign w_ptr_nxt = (w_gidx == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (w_gidx + IDW'(1));

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; an ack edge seen in the timeout cycle takes priority.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_fire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = REQ_HI;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ_HI: begin
        if (w_ack_s) begin
          w_state_nxt = REQ_LO;
        end else if (w_tmo_hit) begin
          w_state_nxt = REQ_LO;
          w_tmo_fire  = 1'b1;
        end else begin
          w_state_nxt = REQ_HI;
        end
      end
      REQ_LO: begin
        if (!w_ack_s) begin
          w_state_nxt = IDLE;
        end else if (w_tmo_hit) begin
          w_state_nxt = IDLE;
          w_tmo_fire  = 1'b1;
        end else begin
          w_state_nxt = REQ_LO;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM outputs; r_abort suppresses xfer_done after a REQ_HI timeout.
  always_comb begin
    w_xreq_nxt  = r_xreq;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_abort_nxt = r_abort;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_xreq_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
          w_abort_nxt = 1'b0;
        end else begin
          w_xreq_nxt  = 1'b0;
        end
      end
      REQ_HI: begin
        if (w_state_nxt == REQ_LO) begin
          w_xreq_nxt  = 1'b0;
          w_abort_nxt = w_tmo_fire;
        end else begin
          w_xreq_nxt  = 1'b1;
        end
      end
      REQ_LO: begin
        if (w_state_nxt == IDLE) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = !w_tmo_fire && !r_abort;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_xreq_nxt = 1'b0;
        w_busy_nxt = 1'b0;
      end
    endcase

    if (w_tmo_fire) begin
      w_tmo_err_nxt = 1'b1;
    end else if (err_clr) begin
      w_tmo_err_nxt = 1'b0;
    end else begin
      w_tmo_err_nxt = r_tmo_err;
    end

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = {TMO_W{1'b0}};
    end else if (r_state != IDLE) begin
      w_cnt_nxt = r_cnt + TMO_W'(1);
    end else begin
      w_cnt_nxt = {TMO_W{1'b0}};
    end
  end

  // Registered control outputs and phase timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xreq    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tmo_err <= 1'b0;
      r_abort   <= 1'b0;
      r_cnt     <= {TMO_W{1'b0}};
    end else begin
      r_xreq    <= w_xreq_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_tmo_err <= w_tmo_err_nxt;
      r_abort   <= w_abort_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Word, owner and rr pointer only move on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xdata <= {DW{1'b0}};
      r_xid   <= {IDW{1'b0}};
      r_ptr   <= {IDW{1'b0}};
    end else if (w_accept) begin
      r_xdata <= req_data[w_gidx*DW +: DW];
      r_xid   <= w_gidx;
      r_ptr   <= w_ptr_nxt;
    end else begin
      r_xdata <= r_xdata;
      r_xid   <= r_xid;
      r_ptr   <= r_ptr;
    end
  end

  assign req_ready = w_grant;
  assign xreq      = r_xreq;
  assign xdata     = r_xdata;
  assign xid       = r_xid;
  assign busy      = r_busy;
  assign xfer_done = r_done;
  assign tmo_err   = r_tmo_err;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: single transfer, round-robin, both timeouts,
// disabled timeout and reset mid-transfer; expectations are hand-derived cycle counts.
module tb_cdc_handshake_tx;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        xreq;
  logic [31:0] xdata;
  logic [0:0]  xid;
  logic        xack;
  logic        busy;
  logic        xfer_done;
  logic [15:0] tmo_limit;
  logic        tmo_err;
  logic        err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  cdc_handshake_tx #(.DW(32), .NREQ(2), .TMO_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .xreq      (xreq),
    .xdata     (xdata),
    .xid       (xid),
    .xack      (xack),
    .busy      (busy),
    .xfer_done (xfer_done),
    .tmo_limit (tmo_limit),
    .tmo_err   (tmo_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xreq(input logic val, input int budget, input string tag);
    int n = 0;
    while (xreq !== val && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(xreq), 64'(val));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (xfer_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(xfer_done), 64'd1);
  endtask

  initial begin
    logic seen;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_data  = 64'd0;
    xack      = 1'b0;
    tmo_limit = 16'd0;
    err_clr   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_xreq", 64'(xreq), 64'd0);
    check("rst_xdata", 64'(xdata), 64'd0);
    check("rst_xid", 64'(xid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(xfer_done), 64'd0);
    check("rst_tmo_err", 64'(tmo_err), 64'd0);
    reset = 1'b0;
    tick();

    // Single transfer
    req_data  = {32'h0000_0000, 32'hA5A5_0001};
    req_valid = 2'b01;
    #1;
    check("t1_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    check("t1_xreq_rise", 64'(xreq), 64'd1);
    check("t1_xdata", 64'(xdata), 64'hA5A5_0001);
    check("t1_xid", 64'(xid), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready_busy", 64'(req_ready), 64'd0);
    tick();
    tick();
    xack = 1'b1;
    tick();
    tick();
    tick();
    check("t1_xreq_hold3", 64'(xreq), 64'd1);
    tick();
    check("t1_xreq_fall4", 64'(xreq), 64'd0);
    tick();
    tick();
    xack = 1'b0;
    tick();
    tick();
    tick();
    check("t1_done_early", 64'(xfer_done), 64'd0);
    check("t1_busy_lo", 64'(busy), 64'd1);
    tick();
    check("t1_done_pulse", 64'(xfer_done), 64'd1);
    check("t1_busy_end", 64'(busy), 64'd0);
    tick();
    check("t1_done_once", 64'(xfer_done), 64'd0);

    // Round-robin from a freshly reset pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    req_data  = {32'h0000_0022, 32'h0000_0011};
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_xreq(1'b1, 10, "rr_xreq_up");
      check("rr_xid", 64'(xid), 64'(g % 2));
      check("rr_xdata", 64'(xdata), (g % 2 == 1) ? 64'h22 : 64'h11);
      xack = 1'b1;
      wait_xreq(1'b0, 10, "rr_xreq_down");
      xack = 1'b0;
      wait_done(10, "rr_done");
      check("rr_next_ready", 64'(req_ready), (g % 2 == 1) ? 64'd1 : 64'd2);
      if (g == 3) begin
        req_valid = 2'b00;
      end
    end
    tick();
    check("rr_idle_xreq", 64'(xreq), 64'd0);

    // Timeout in REQ_HI, xack never rises
    tmo_limit = 16'd8;
    req_data  = {32'h0000_0000, 32'h0000_0033};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (xfer_done === 1'b1) seen = 1'b1;
    end
    check("tmo_hi_xreq7", 64'(xreq), 64'd1);
    check("tmo_hi_err7", 64'(tmo_err), 64'd0);
    tick();
    check("tmo_hi_xreq8", 64'(xreq), 64'd0);
    check("tmo_hi_err8", 64'(tmo_err), 64'd1);
    check("tmo_hi_busy8", 64'(busy), 64'd1);
    tick();
    if (xfer_done === 1'b1) seen = 1'b1;
    check("tmo_hi_idle", 64'(busy), 64'd0);
    tick();
    if (xfer_done === 1'b1) seen = 1'b1;
    check("tmo_hi_no_done", 64'(seen), 64'd0);

    // Stuck ack in REQ_LO
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_lo_pre_clr", 64'(tmo_err), 64'd0);
    req_data  = {32'h0000_0000, 32'h0000_0044};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    xack = 1'b1;
    tick();
    tick();
    tick();
    check("tmo_lo_xreq_hi", 64'(xreq), 64'd1);
    tick();
    check("tmo_lo_xreq_lo", 64'(xreq), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (xfer_done === 1'b1) seen = 1'b1;
    end
    check("tmo_lo_busy7", 64'(busy), 64'd1);
    check("tmo_lo_err7", 64'(tmo_err), 64'd0);
    tick();
    if (xfer_done === 1'b1) seen = 1'b1;
    check("tmo_lo_busy8", 64'(busy), 64'd0);
    check("tmo_lo_err8", 64'(tmo_err), 64'd1);
    check("tmo_lo_no_done", 64'(seen), 64'd0);
    tick();
    check("tmo_lo_sticky", 64'(tmo_err), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_lo_clr", 64'(tmo_err), 64'd0);
    xack = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Timeout disabled, then reset mid-transfer
    tmo_limit = 16'd0;
    req_data  = {32'h0000_0066, 32'h0000_0055};
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    check("dis_xreq", 64'(xreq), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tmo_err !== 1'b0) seen = 1'b1;
    end
    check("dis_no_err", 64'(seen), 64'd0);
    check("dis_xreq_held", 64'(xreq), 64'd1);
    check("dis_busy_held", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_xreq", 64'(xreq), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    tick();
    reset     = 1'b0;
    req_valid = 2'b11;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    check("post_rst_xid", 64'(xid), 64'd0);
    check("post_rst_xdata", 64'(xdata), 64'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
